// File: rtl/lut_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// lut_cfg_ctrl
//
// Run-time programmable N-input lookup table. A truth table arrives as a
// serial valid/ready bit stream (MSB = entry 2^N-1 first). It is collected
// in a shadow register and then copied atomically into the active table.
// Lookups are answered continuously from the active table, with a one-cycle
// registered result.
//
// Optional feature macro: LUT_PARITY_EN
//   When defined, one even-parity bit follows the table bits. A mismatch
//   discards the load and sets the sticky err flag. When undefined, err is
//   tied to 0.
//
// Parameters
//   N     number of LUT inputs (1..6); the table depth is 2^N bits
//   INIT  active table contents after reset
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cfg_start  in   begin a load (honoured in IDLE only)
//   cfg_abort  in   drop the load in progress and return to IDLE
//   cfg_valid  in   cfg_bit carries a table bit
//   cfg_bit    in   serial table bit
//   cfg_ready  out  a bit is accepted this cycle when cfg_valid is also high
//   busy       out  load in progress
//   done       out  one-cycle pulse while the new table is committed
//   err        out  sticky parity error
//   x          in   lookup address
//   x_valid    in   lookup request
//   y          out  registered active[x]
//   y_valid    out  y holds a fresh result
// ---------------------------------------------------------------------------
module lut_cfg_ctrl #(
    parameter int                N    = 4,
    parameter logic [(1<<N)-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_start,
    input  logic         cfg_abort,
    input  logic         cfg_valid,
    input  logic         cfg_bit,
    output logic         cfg_ready,
    output logic         busy,
    output logic         done,
    output logic         err,
    input  logic [N-1:0] x,
    input  logic         x_valid,
    output logic         y,
    output logic         y_valid
);
    localparam int            DEPTH = 1 << N;
    localparam int            CW    = N + 1;
    localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_PARITY = 2'd2,
        S_COMMIT = 2'd3
    } state_e;

    state_e           state_q;
    logic [DEPTH-1:0] shadow_q;
    logic [DEPTH-1:0] active_q;
    logic [CW-1:0]    cnt_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             y_q;
    logic             y_valid_q;
    logic             bit_acc;

    // ready_q is high exactly in the states that take bits, so it doubles
    // as the "in LOAD/PARITY" qualifier for the handshake.
    assign bit_acc = cfg_valid && ready_q;

`ifdef LUT_PARITY_EN
    logic err_q;
    logic parity_ok;
    // Even parity: table bits XOR the parity bit must be zero.
    assign parity_ok = ~(^shadow_q ^ cfg_bit);
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

    assign cfg_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign y         = y_q;
    assign y_valid   = y_valid_q;

    // Load controller: all control outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            active_q <= INIT;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef LUT_PARITY_EN
            err_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_start) begin
                        state_q  <= S_LOAD;
                        cnt_q    <= '0;
                        shadow_q <= '0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b1;
`ifdef LUT_PARITY_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    // Abort wins over a bit offered in the same cycle.
                    if (cfg_abort) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (bit_acc) begin
                        shadow_q <= {shadow_q[DEPTH-2:0], cfg_bit};
                        cnt_q    <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
`ifdef LUT_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_COMMIT;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef LUT_PARITY_EN
                S_PARITY: begin
                    if (cfg_abort) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (bit_acc) begin
                        ready_q <= 1'b0;
                        if (parity_ok) begin
                            state_q <= S_COMMIT;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                S_COMMIT: begin
                    active_q <= shadow_q;
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Lookup path: independent of the loader; reads active_q before any
    // commit landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= x_valid;
            if (x_valid) begin
                y_q <= active_q[x];
            end
        end
    end

endmodule

// File: tb/tb_lut_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lut_cfg_ctrl
//
// Self-checking bench for lut_cfg_ctrl (N=4, INIT=16'h8000). A behavioural
// model holds the active table as a plain bit vector and applies a load's
// new contents one edge after the edge that shows done; lookups are
// predicted from that vector. Randomised gaps, lookups, tables and aborts.
// ---------------------------------------------------------------------------
module tb_lut_cfg_ctrl;
    localparam int          N      = 4;
    localparam int          D      = 16;
    localparam logic [15:0] INIT_V = 16'h8000;
`ifdef LUT_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_start, cfg_abort, cfg_valid, cfg_bit;
    logic         cfg_ready, busy, done, err;
    logic [N-1:0] x;
    logic         x_valid, y, y_valid;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [15:0] m_active;
    logic [15:0] m_new;
    bit          m_commit_next;
    logic        m_y;
    logic        m_err;
    bit          fix_x;
    logic [3:0]  fix_x_val;

    always #5 clk = ~clk;

    lut_cfg_ctrl #(.N(N), .INIT(INIT_V)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_abort (cfg_abort),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .x         (x),
        .x_valid   (x_valid),
        .y         (y),
        .y_valid   (y_valid)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: drive a lookup, predict its result from the model table,
    // apply a pending commit after the lookup is sampled, then check.
    task automatic cycle();
        logic [3:0] xs;
        logic       xv;
        xv = fix_x ? 1'b1 : ($urandom_range(0, 3) != 0);
        xs = fix_x ? fix_x_val : 4'($urandom_range(0, 15));
        x       = xs;
        x_valid = xv;
        @(posedge clk);
        if (xv) m_y = m_active[xs];
        if (m_commit_next) begin
            m_active      = m_new;
            m_commit_next = 1'b0;
        end
        #1;
        chk_eq("y_valid", y_valid, xv);
        chk_eq("y", y, m_y);
    endtask

    task automatic look(input logic [3:0] a, input logic e);
        bit         sv_fix;
        logic [3:0] sv_val;
        sv_fix    = fix_x;
        sv_val    = fix_x_val;
        fix_x     = 1'b1;
        fix_x_val = a;
        cycle();
        chk_eq("y_literal", y, e);
        fix_x     = sv_fix;
        fix_x_val = sv_val;
    endtask

    task automatic sweep();
        bit sv_fix;
        sv_fix = fix_x;
        fix_x  = 1'b1;
        for (int i = 0; i < D; i++) begin
            fix_x_val = 4'(i);
            cycle();
        end
        fix_x = sv_fix;
    endtask

    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            cfg_valid = 1'($urandom);
            cfg_bit   = 1'($urandom);
            cycle();
            chk_eq("idle_busy", busy, 0);
            chk_eq("idle_ready", cfg_ready, 0);
        end
        cfg_valid = 1'b0;
    endtask

    // Full load transaction. abort_at >= 0 aborts once that many bits are in;
    // extra_start pulses cfg_start mid-load (must be ignored).
    task automatic do_load(input logic [15:0] tbl, input int gap_pct, input int abort_at,
                           input bit pflip, input bit extra_start);
        int   acc;
        int   cyc;
        int   total;
        bit   fin;
        bit   ok;
        logic pbit;
        acc   = 0;
        cyc   = 0;
        fin   = 1'b0;
        total = D + int'(PAR_EN);
        ok    = !(PAR_EN && pflip);
        pbit  = (^tbl) ^ pflip;
        cfg_start = 1'b1;
        cycle();
        cfg_start = 1'b0;
        m_err = 1'b0;
        chk_eq("start_busy", busy, 1);
        chk_eq("start_ready", cfg_ready, 1);
        chk_eq("start_err", err, m_err);
        while (!fin && cyc < 200) begin
            cyc++;
            if (abort_at >= 0 && acc == abort_at) begin
                cfg_abort = 1'b1;
                cfg_valid = 1'($urandom);
                cfg_bit   = 1'($urandom);
                cycle();
                cfg_abort = 1'b0;
                cfg_valid = 1'b0;
                chk_eq("abort_busy", busy, 0);
                chk_eq("abort_ready", cfg_ready, 0);
                chk_eq("abort_done", done, 0);
                fin = 1'b1;
            end else begin
                cfg_valid = ($urandom_range(0, 99) >= gap_pct);
                cfg_bit   = (acc < D) ? tbl[D-1-acc] : pbit;
                if (!cfg_valid) cfg_bit = 1'($urandom);
                cfg_start = extra_start && (acc == 3);
                cycle();
                cfg_start = 1'b0;
                if (cfg_valid) acc++;
                if (acc == total) begin
                    if (ok) begin
                        chk_eq("commit_done", done, 1);
                        chk_eq("commit_busy", busy, 1);
                        m_new         = tbl;
                        m_commit_next = 1'b1;
                    end else begin
                        chk_eq("perr_done", done, 0);
                        chk_eq("perr_busy", busy, 0);
                        m_err = 1'b1;
                    end
                    chk_eq("end_ready", cfg_ready, 0);
                    chk_eq("end_err", err, m_err);
                    if (gap_pct == 0) chk_eq("done_latency", cyc, total);
                    cfg_valid = 1'($urandom);
                    cfg_bit   = 1'($urandom);
                    cycle();
                    cfg_valid = 1'b0;
                    chk_eq("post_done", done, 0);
                    chk_eq("post_busy", busy, 0);
                    chk_eq("post_ready", cfg_ready, 0);
                    chk_eq("post_err", err, m_err);
                    fin = 1'b1;
                end else begin
                    chk_eq("load_done", done, 0);
                    chk_eq("load_busy", busy, 1);
                    chk_eq("load_ready", cfg_ready, 1);
                end
            end
        end
        if (!fin) chk_eq("load_timeout", 0, 1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cfg_start = 1'b0; cfg_abort = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        x = '0; x_valid = 1'b0;
        fix_x = 1'b0; fix_x_val = '0;
        m_active = INIT_V; m_new = '0; m_commit_next = 1'b0; m_y = 1'b0; m_err = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_ready", cfg_ready, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_err", err, 0);
        chk_eq("rst_y", y, 0);
        chk_eq("rst_yvalid", y_valid, 0);
        rst_n = 1'b1;

        // INIT table: only entry 15 set
        sweep();
        look(4'd15, 1'b1);
        look(4'd0, 1'b0);
        look(4'd7, 1'b0);
        idle_noise(5);

        // Continuous load of A5C3
        do_load(16'hA5C3, 0, -1, 1'b0, 1'b0);
        sweep();
        look(4'd0, 1'b1);
        look(4'd2, 1'b0);
        look(4'd6, 1'b1);
        look(4'd15, 1'b1);

        // FFFF with gaps while looking up x=3 every cycle
        fix_x = 1'b1; fix_x_val = 4'd3;
        do_load(16'hFFFF, 40, -1, 1'b0, 1'b0);
        cycle();
        fix_x = 1'b0;
        look(4'd3, 1'b1);

        // Abort after 7 bits, with an ignored start pulse during LOAD
        do_load(16'h1234, 0, 7, 1'b0, 1'b1);
        sweep();
        look(4'd5, 1'b1);
        idle_noise(3);

        // Ignored start pulse during a full load keeps the latency intact
        do_load(16'h0F0F, 0, -1, 1'b0, 1'b1);
        look(4'd15, 1'b0);

        // Reset in the middle of a load (after 9 bits)
        fix_x = 1'b1; fix_x_val = 4'd15;
        cfg_start = 1'b1;
        cycle();
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cfg_bit = 1'($urandom);
            cycle();
        end
        chk_eq("midload_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        m_y = 1'b0; m_commit_next = 1'b0; m_active = INIT_V; m_err = 1'b0;
        chk_eq("arst_yvalid", y_valid, 0);
        chk_eq("arst_busy", busy, 0);
        chk_eq("arst_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        fix_x = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sweep();
        look(4'd15, 1'b1);

        if (PAR_EN) begin
            do_load(16'h0001, 0, -1, 1'b0, 1'b0);
            look(4'd0, 1'b1);
            do_load(16'hFFF0, 0, -1, 1'b1, 1'b0);
            look(4'd0, 1'b1);
            look(4'd4, 1'b0);
            do_load(16'h0001, 0, -1, 1'b1, 1'b0);
            look(4'd0, 1'b1);
        end

        // Randomised loads
        for (int r = 0; r < 8; r++) begin
            do_load(16'($urandom), $urandom_range(0, 50),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                    1'($urandom), 1'($urandom));
            sweep();
            idle_noise(2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
